proc_ctrl_gen: RTL and testbench

- Parametrised successor of the multicycle processor control unit: register file, A/G accumulator path and shared ALU under an explicit FSM.
- Executes one instruction per Run-qualified fetch over one shared bus.
- Adds generic data width, register count, a Run-qualified fetch handshake, a two-word mvi without stall counting, and deterministic reset.
- Sits between the instruction/data source (DIN) and downstream datapath observers (BusWires, Done).

---
 rtl/proc_ctrl_gen_pkg.sv | 34 +++
 rtl/proc_ctrl_gen_if.sv | 27 ++
 rtl/proc_ctrl_gen_alu.sv | 27 ++
 rtl/proc_ctrl_gen.sv | 124 ++++++++++++
 tb/tb_proc_ctrl_gen.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_ctrl_gen_pkg.sv
// Shared opcodes, FSM states and bus-source selects for the multicycle processor control unit.
// Bus sources are one-hot so the bus mux is a plain AND-OR with no priority.
package proc_gen_pkg;

    localparam logic [3:0] OP_MV   = 4'd0;
    localparam logic [3:0] OP_MVI  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_MVNZ = 4'd8;

    typedef enum logic [2:0] {
        FETCH,
        T1,
        T2,
        T3,
        IMM
    } state_t;

    typedef enum logic [3:0] {
        SRC_NONE = 4'b0000,
        SRC_R    = 4'b0001,
        SRC_G    = 4'b0010,
        SRC_DIN  = 4'b0100
    } src_t;

    function automatic logic is_alu(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_SRL);
    endfunction

endpackage

// File: rtl/proc_ctrl_gen_if.sv
// Instruction/data source handshake plus the observable datapath outputs of the control unit.
// Run qualifies DIN; no backpressure signal, the source simply holds Run low until the unit is ready.
interface proc_ctrl_gen_if #(
    parameter int W = 16
);
    logic         Run;
    logic [W-1:0] DIN;
    logic         Done;
    logic [W-1:0] BusWires;
    logic         Busy;

    modport master (
        output Run,
        output DIN,
        input  Done,
        input  BusWires,
        input  Busy
    );

    modport slave (
        input  Run,
        input  DIN,
        output Done,
        output BusWires,
        output Busy
    );
endinterface

// File: rtl/proc_ctrl_gen_alu.sv
// Shared ALU: add/sub modulo 2^W, or, signed slt, logical shifts by B[SHW-1:0].
// Purely combinational, zero latency, no flow control.
module proc_gen_alu
    import proc_gen_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    localparam int SHW = $clog2(W);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_OR:   y = a | b;
            OP_SLT:  y = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  y = a << b[SHW-1:0];
            OP_SRL:  y = a >> b[SHW-1:0];
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/proc_ctrl_gen.sv
// Multicycle control unit: register file, A/G accumulators, shared bus; mv 2, ALU 4, mvi 3+wait cycles.
// DIN consumed only when Run=1 in FETCH/IMM, otherwise ignored; opcode 8 is mvnz under PROC_MVNZ_EN.
module proc_ctrl_gen
    import proc_gen_pkg::*;
#(
    parameter int W    = 16,
    parameter int NREG = 8
) (
    input  logic           Clock,
    input  logic           Resetn,
    proc_ctrl_gen_if.slave io
);
    localparam int RB = $clog2(NREG);
    localparam int IW = 4 + 2*RB;

    state_t        state_q, state_d;
    src_t          src;
    logic [W-1:0]  regs [NREG];
    logic [W-1:0]  a_q, g_q;
    logic [W-1:0]  rd_dat, bus_dat, alu_dat;
    logic [IW-1:0] ir_q;
    logic [3:0]    op;
    logic [RB-1:0] rx, ry, rsel;
    logic          ir_ld, a_ld, g_ld, wr_en, done;

    assign op = ir_q[IW-1 -: 4];
    assign rx = ir_q[2*RB-1 -: RB];
    assign ry = ir_q[RB-1:0];

    assign rd_dat  = regs[rsel];
    assign bus_dat = ({W{src[0]}} & rd_dat)
                   | ({W{src[1]}} & g_q)
                   | ({W{src[2]}} & io.DIN);

    proc_gen_alu #(.W(W)) u_alu (
        .op (op),
        .a  (a_q),
        .b  (bus_dat),
        .y  (alu_dat)
    );

    always_comb begin
        state_d = state_q;
        src     = SRC_NONE;
        rsel    = ry;
        ir_ld   = 1'b0;
        a_ld    = 1'b0;
        g_ld    = 1'b0;
        wr_en   = 1'b0;
        done    = 1'b0;
        case (state_q)
            FETCH: begin
                if (io.Run) begin
                    ir_ld   = 1'b1;
                    state_d = T1;
                end
            end
            T1: begin
                state_d = FETCH;
                if (op == OP_MV) begin
                    src   = SRC_R;
                    wr_en = 1'b1;
                    done  = 1'b1;
                end else if (op == OP_MVI) begin
                    state_d = IMM;
                end else if (is_alu(op)) begin
                    src     = SRC_R;
                    rsel    = rx;
                    a_ld    = 1'b1;
                    state_d = T2;
`ifdef PROC_MVNZ_EN
                end else if (op == OP_MVNZ) begin
                    src   = SRC_R;
                    wr_en = (g_q != '0);
                    done  = 1'b1;
`endif
                end else begin
                    done = 1'b1;
                end
            end
            IMM: begin
                if (io.Run) begin
                    src     = SRC_DIN;
                    wr_en   = 1'b1;
                    done    = 1'b1;
                    state_d = FETCH;
                end
            end
            T2: begin
                src     = SRC_R;
                g_ld    = 1'b1;
                state_d = T3;
            end
            T3: begin
                src     = SRC_G;
                wr_en   = 1'b1;
                done    = 1'b1;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Resetn) begin
            state_q <= FETCH;
            ir_q    <= '0;
            a_q     <= '0;
            g_q     <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            state_q <= state_d;
            if (ir_ld) ir_q <= io.DIN[IW-1:0];
            if (a_ld)  a_q  <= bus_dat;
            if (g_ld)  g_q  <= alu_dat;
            if (wr_en) regs[rx] <= bus_dat;
        end
    end

    // Outputs are masked while reset is held so a mid-instruction reset shows nothing.
    assign io.Done     = done & ~Resetn;
    assign io.Busy     = (state_q != FETCH) & ~Resetn;
    assign io.BusWires = Resetn ? '0 : bus_dat;
endmodule

// File: tb/tb_proc_ctrl_gen.sv
module tb_proc_ctrl_gen;
    typedef struct {
        logic [15:0] val;
        int          lat;
        string       name;
    } sb_t;

    logic Clock = 1'b0;
    logic Resetn;
    always #5 Clock = ~Clock;

    proc_ctrl_gen_if #(.W(16)) if0 ();
    proc_ctrl_gen_if #(.W(8))  if8 ();

    proc_ctrl_gen #(.W(16), .NREG(8)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .io     (if0)
    );

    proc_ctrl_gen #(.W(8), .NREG(4)) dut8 (
        .Clock  (Clock),
        .Resetn (Resetn),
        .io     (if8)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          fetch_cyc = 0;
    sb_t         sbq[$];
    sb_t         mon_e;
    logic [15:0] m_r [8];
    logic [15:0] m_g;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] mk(input int op, input int x, input int y);
        logic [15:0] w;
        w      = '0;
        w[9:6] = op[3:0];
        w[5:3] = x[2:0];
        w[2:0] = y[2:0];
        return w;
    endfunction

    function automatic logic [15:0] alu_ref(input int op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2:       return a + b;
            3:       return a - b;
            4:       return a | b;
            5:       return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            6:       return a << b[3:0];
            default: return a >> b[3:0];
        endcase
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) m_r[i] = '0;
        m_g = '0;
    endtask

    // Scoreboard monitor: every Done pulse is matched against the oldest expectation.
    always @(negedge Clock) begin
        cyc++;
        if (!Resetn) begin
            if (if0.Run && !if0.Busy) fetch_cyc = cyc;
            if (if0.Done) begin
                if (sbq.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk({mon_e.name, "_bus"}, {16'd0, if0.BusWires}, {16'd0, mon_e.val});
                    if (mon_e.lat != 0)
                        chk({mon_e.name, "_lat"}, cyc - fetch_cyc + 1, mon_e.lat);
                end
            end
        end
    end

    task automatic issue(input int op, input int x, input int y, input logic [15:0] imm, input int waits);
        sb_t         e;
        logic [15:0] a, b, r;
        int          busy_n;
        int          t;
        a      = m_r[x];
        b      = m_r[y];
        e.name = $sformatf("op%0d_r%0d_r%0d", op, x, y);
        busy_n = 1;
        if (op == 0) begin
            e.val = b; e.lat = 2; m_r[x] = b;
        end else if (op == 1) begin
            e.val = imm; e.lat = 0; m_r[x] = imm;
        end else if (op <= 7) begin
            r = alu_ref(op, a, b);
            e.val = r; e.lat = 4; m_r[x] = r; m_g = r; busy_n = 3;
`ifdef PROC_MVNZ_EN
        end else if (op == 8) begin
            e.val = b; e.lat = 2;
            if (m_g != 0) m_r[x] = b;
`endif
        end else begin
            e.val = '0; e.lat = 2;
        end
        sbq.push_back(e);

        if0.Run = 1'b1;
        if0.DIN = mk(op, x, y);
        @(posedge Clock); #1;
        // Run is held high with junk while busy: it must be ignored.
        for (int i = 0; i < busy_n; i++) begin
            if0.Run = 1'b1;
            if0.DIN = 16'($urandom);
            @(posedge Clock); #1;
        end
        if (op == 1) begin
            if0.Run = 1'b0;
            repeat (waits) begin @(posedge Clock); #1; end
            if0.Run = 1'b1;
            if0.DIN = imm;
            @(posedge Clock); #1;
        end
        if0.Run = 1'b0;
        t = 0;
        while (if0.Busy && t < 20) begin
            @(posedge Clock); #1;
            t++;
        end
        if (if0.Busy) chk("busy_timeout", 32'd1, 32'd0);
    endtask

    task automatic run8(input string nm, input logic [7:0] din, input logic [7:0] exp);
        if8.Run = 1'b1;
        if8.DIN = din;
        @(posedge Clock); #1;
        if8.Run = 1'b0;
        if8.DIN = '0;
        @(negedge Clock);
        chk({nm, "_done"}, {31'd0, if8.Done}, 32'd1);
        chk({nm, "_bus"}, {24'd0, if8.BusWires}, {24'd0, exp});
        @(posedge Clock); #1;
        chk({nm, "_idle"}, {31'd0, if8.Busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        Resetn  = 1'b1;
        if0.Run = 1'b0;
        if0.DIN = '0;
        if8.Run = 1'b0;
        if8.DIN = '0;
        clear_model();
        repeat (2) begin
            @(negedge Clock);
            chk("rst_done", {31'd0, if0.Done}, 32'd0);
            chk("rst_busy", {31'd0, if0.Busy}, 32'd0);
            chk("rst_bus", {16'd0, if0.BusWires}, 32'd0);
        end
        @(posedge Clock); #1;
        Resetn = 1'b0;

        for (int k = 0; k < 8; k++) issue(0, k, k, '0, 0);

        issue(1, 0, 0, 16'h00A5, 3);
        issue(0, 0, 0, '0, 0);

        issue(1, 1, 0, 16'hFFFF, 0);
        issue(1, 2, 0, 16'h0001, 1);
        issue(2, 1, 2, '0, 0);
        issue(3, 1, 2, '0, 0);

        issue(1, 3, 0, 16'h8000, 0);
        issue(1, 4, 0, 16'h0001, 0);
        issue(5, 3, 4, '0, 0);
        issue(1, 5, 0, 16'h0001, 2);
        issue(1, 6, 0, 16'h0004, 0);
        issue(6, 5, 6, '0, 0);
        issue(7, 5, 6, '0, 0);
        issue(2, 6, 6, '0, 0);

        // Reset while an add is sitting in T2.
        if0.Run = 1'b1;
        if0.DIN = mk(2, 1, 2);
        @(posedge Clock); #1;
        if0.Run = 1'b0;
        @(posedge Clock); #1;
        Resetn = 1'b1;
        repeat (2) begin
            @(negedge Clock);
            chk("midrst_done", {31'd0, if0.Done}, 32'd0);
            chk("midrst_busy", {31'd0, if0.Busy}, 32'd0);
            chk("midrst_bus", {16'd0, if0.BusWires}, 32'd0);
            @(posedge Clock); #1;
        end
        Resetn = 1'b0;
        clear_model();
        for (int k = 0; k < 8; k++) issue(0, k, k, '0, 0);

        // Opcode 8 with G=0, then with G=5.
        issue(1, 1, 0, 16'h0007, 0);
        issue(8, 0, 1, '0, 0);
        issue(0, 0, 0, '0, 0);
        issue(1, 2, 0, 16'h0002, 0);
        issue(1, 3, 0, 16'h0003, 0);
        issue(2, 2, 3, '0, 0);
        issue(8, 0, 1, '0, 0);
        issue(0, 0, 0, '0, 0);

        for (int n = 0; n < 160; n++) begin
            int op;
            op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 7));
            issue(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  16'($urandom), int'($urandom_range(0, 3)));
        end
        for (int k = 0; k < 8; k++) issue(0, k, k, '0, 0);

        // Narrow build: W=8, NREG=4, format {op[7:4], X[3:2], Y[1:0]}.
        if8.Run = 1'b1;
        if8.DIN = 8'h1C;
        @(posedge Clock); #1;
        if8.Run = 1'b0;
        @(posedge Clock); #1;
        @(negedge Clock);
        chk("w8_mvi_wait_done", {31'd0, if8.Done}, 32'd0);
        @(posedge Clock); #1;
        if8.Run = 1'b1;
        if8.DIN = 8'h7E;
        @(negedge Clock);
        chk("w8_mvi_done", {31'd0, if8.Done}, 32'd1);
        chk("w8_mvi_bus", {24'd0, if8.BusWires}, 32'h7E);
        @(posedge Clock); #1;
        if8.Run = 1'b0;
        chk("w8_mvi_idle", {31'd0, if8.Busy}, 32'd0);
        run8("w8_mv_r2_r3", 8'h0B, 8'h7E);
        run8("w8_op12", 8'hCB, 8'h00);
        run8("w8_mv_r2_r2", 8'h0A, 8'h7E);
        run8("w8_mv_r3_r3", 8'h0F, 8'h7E);
        run8("w8_mv_r0_r0", 8'h00, 8'h00);

        repeat (2) @(posedge Clock);
        chk("sb_drain", sbq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
